// File: rtl/alu_pkg.sv
// Shared types and constants for the divider.
// FSM state encoding and default datapath width.
package alu_pkg;

  localparam int DIV_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/sign_mag_conv.sv
// Two's-complement negate-on-demand helper.
// Turns signed into magnitude and magnitude into signed.
module sign_mag_conv #(
  parameter int W = 8
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  // negate when asked, otherwise pass through
  always_comb begin
    result = value;
    if (negate) result = (~value) + 1'b1;
  end

endmodule

// File: rtl/nonrestoring_divider.sv
// Multi-cycle signed non-restoring divider, one quotient bit per cycle.
// Define DIV_ZERO_CHECK_EN to short-cut and flag division by zero.
module nonrestoring_divider
  import alu_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         dbz
);

  localparam int CW = $clog2(W + 1);

`ifdef DIV_ZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W:0]    r_q;
  logic [W-1:0]  q_q;
  logic [W-1:0]  d_q;
  logic          sa;
  logic          sb;
  logic          dz;

  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;
  logic          zdiv;
  logic [W:0]    r_shift;
  logic [W:0]    r_nxt;
  logic [W:0]    r_fix;
  logic [W-1:0]  rmag;
  logic [W-1:0]  q_sgn;
  logic [W-1:0]  r_sgn;
  logic [W-1:0]  q_out;

  sign_mag_conv #(.W(W)) u_a (
    .value  (dividend),
    .negate (dividend[W-1]),
    .result (a_mag)
  );

  sign_mag_conv #(.W(W)) u_b (
    .value  (divisor),
    .negate (divisor[W-1]),
    .result (b_mag)
  );

  sign_mag_conv #(.W(W)) u_q (
    .value  (q_q),
    .negate (sa ^ sb),
    .result (q_sgn)
  );

  sign_mag_conv #(.W(W)) u_r (
    .value  (rmag),
    .negate (sa),
    .result (r_sgn)
  );

  // iteration step and final remainder correction
  always_comb begin
    zdiv    = ZCHK && (divisor == '0);
    r_shift = {r_q[W-1:0], q_q[W-1]};
    r_nxt   = r_q[W] ? r_shift + {1'b0, d_q}
                     : r_shift - {1'b0, d_q};
    r_fix   = r_q[W] ? r_q + {1'b0, d_q} : r_q;
    rmag    = dz ? q_q : r_fix[W-1:0];
    q_out   = dz ? '1 : q_sgn;
  end

  // control FSM with registered status and results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      r_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      dz        <= 1'b0;
      busy      <= 1'b0;
      ready     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sa    <= dividend[W-1];
            sb    <= divisor[W-1];
            q_q   <= a_mag;
            d_q   <= b_mag;
            r_q   <= '0;
            cnt   <= CW'(W);
            dz    <= zdiv;
            busy  <= 1'b1;
            state <= zdiv ? FIX : EXEC;
          end
        end
        EXEC: begin
          r_q <= r_nxt;
          q_q <= {q_q[W-2:0], ~r_nxt[W]};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          quotient  <= q_out;
          remainder <= r_sgn;
          dbz       <= dz;
          busy      <= 1'b0;
          ready     <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (!start) begin
            ready <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Directed self-checking bench for nonrestoring_divider (W=8).
// Define DIV_ZERO_CHECK_EN to also exercise the divide-by-zero path.
module tb_nonrestoring_divider;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dbz;

  int checks;
  int failures;

  nonrestoring_divider #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .ready     (ready),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // accept edge counts as edge 1; ready expected on edge lat
  task automatic run_div(input string tag,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ez, input int lat, input bit pulse);
    int n;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    n = 1;
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    while (n < 40) begin
      @(posedge clk);
      n++;
      #1;
      if (ready) break;
      start = (pulse && n == 3);
    end
    start = 1'b0;
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_q"}, {24'd0, quotient}, {24'd0, eq});
    chk({tag, "_r"}, {24'd0, remainder}, {24'd0, er});
    chk({tag, "_dbz"}, {31'd0, dbz}, {31'd0, ez});
    @(posedge clk);
    #1;
    chk({tag, "_idle"}, {31'd0, ready}, 32'd0);
  endtask

  initial begin
    int hold_ok;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_q", {24'd0, quotient}, 32'd0);
    chk("rst_r", {24'd0, remainder}, 32'd0);
    chk("rst_dbz", {31'd0, dbz}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_div("pp", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 10, 1'b0);
    run_div("np", 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, 10, 1'b0);
    run_div("pn", 8'd100, 8'hF9, 8'hF2, 8'd2, 1'b0, 10, 1'b0);
    run_div("nn", 8'h9C, 8'hF9, 8'd14, 8'hFE, 1'b0, 10, 1'b0);
    run_div("wrap", 8'h80, 8'hFF, 8'h80, 8'd0, 1'b0, 10, 1'b0);
    run_div("eq", 8'd127, 8'd127, 8'd1, 8'd0, 1'b0, 10, 1'b0);
    run_div("small", 8'd3, 8'd100, 8'd0, 8'd3, 1'b0, 10, 1'b0);
    run_div("pulse", 8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, 10, 1'b1);

`ifdef DIV_ZERO_CHECK_EN
    run_div("dz", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 2, 1'b0);
    run_div("after_dz", 8'd6, 8'd3, 8'd2, 8'd0, 1'b0, 10, 1'b0);
`endif

    // held start: one division, then ready stays up
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd20;
    divisor  = 8'd4;
    repeat (10) @(posedge clk);
    #1;
    chk("hold_ready", {31'd0, ready}, 32'd1);
    chk("hold_q", {24'd0, quotient}, 32'd5);
    dividend = 8'd9;
    divisor  = 8'd2;
    hold_ok  = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (ready && !busy && quotient == 8'd5) hold_ok++;
    end
    chk("hold_stable", hold_ok, 20);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_rel_ready", {31'd0, ready}, 32'd0);
    chk("hold_keep_q", {24'd0, quotient}, 32'd5);

    // asynchronous reset in the 4th EXEC cycle
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, ready}, 32'd0);
    chk("mid_rst_q", {24'd0, quotient}, 32'd0);
    chk("mid_rst_r", {24'd0, remainder}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_div("post_rst", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 10, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
